// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared types for the bus transfer sequencer: phase encoding, word widths,
// request packing and the request legality rule.
package bus_transfer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int W8    = 5;
  localparam int W16   = 4;
  localparam int ID_W  = 5;
  localparam int REQ_W = 1 + 2 * ID_W;

  typedef struct packed {
    logic            wide;
    logic [ID_W-1:0] src;
    logic [ID_W-1:0] dst;
  } req_t;

  // A request must name two distinct, non-zero devices within the id range of its width.
  function automatic logic req_legal(input req_t r, input int max8, input int max16);
    int lim;
    lim = r.wide ? max16 : max8;
    return (r.src != '0) && (r.dst != '0) && (r.src != r.dst) &&
           (int'(r.src) <= lim) && (int'(r.dst) <= lim);
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_fifo.sv
// Request queue for the transfer sequencer: synchronous FIFO of packed
// requests; push on full and pop on empty are ignored.
module transfer_request_fifo
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output req_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Drives the 8/16-bit assert/load decode words: each queued legal request
// plays out as SETUP, LOAD, HOLD; illegal requests are dropped with an o_err pulse.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int MAX_ID_8   = 15,
  parameter int MAX_ID_16  = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic           i_req_wide,
  input  logic [ID_W-1:0] i_req_src,
  input  logic [ID_W-1:0] i_req_dst,
  output logic [W8-1:0]  o_8bit_assert_word,
  output logic [W8-1:0]  o_8bit_load_word,
  output logic [W16-1:0] o_16bit_assert_word,
  output logic [W16-1:0] o_16bit_load_word,
  output logic           o_busy,
  output logic           o_err,
  output logic [7:0]     o_xfer_count
);

  state_t     r_state;
  state_t     w_state_nxt;
  req_t       r_cur;
  req_t       w_head;
  req_t       w_req_in;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_head_legal;
  logic       w_err_nxt;
  logic       r_err;
  logic [7:0] r_count;

  assign w_req_in     = '{wide: i_req_wide, src: i_req_src, dst: i_req_dst};
  assign w_push       = i_req_valid & ~w_full;
  assign w_head_legal = req_legal(w_head, MAX_ID_8, MAX_ID_16);

  transfer_request_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_req_in),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // Illegal heads are only consumed from IDLE, so HOLD falls back to IDLE when one is waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_legal) w_state_nxt = ST_SETUP;
          else              w_err_nxt   = 1'b1;
        end
      end
      ST_SETUP: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!w_empty && w_head_legal) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_pop && w_head_legal) r_cur <= w_head;
      if (r_state == ST_HOLD)    r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    o_8bit_assert_word  = '0;
    o_8bit_load_word    = '0;
    o_16bit_assert_word = '0;
    o_16bit_load_word   = '0;
    if (r_state != ST_IDLE) begin
      if (r_cur.wide) begin
        o_16bit_assert_word = r_cur.src[W16-1:0];
        if (r_state == ST_LOAD) o_16bit_load_word = r_cur.dst[W16-1:0];
      end else begin
        o_8bit_assert_word = r_cur.src;
        if (r_state == ST_LOAD) o_8bit_load_word = r_cur.dst;
      end
    end
  end

  assign o_req_ready  = ~w_full;
  assign o_busy       = (r_state != ST_IDLE) | ~w_empty;
  assign o_err        = r_err;
  assign o_xfer_count = r_count;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: directed timing checks plus
// randomized requests scored against a transaction-level reference model.
module tb_bus_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_req_valid = 1'b0;
  logic       i_req_wide = 1'b0;
  logic [4:0] i_req_src = '0;
  logic [4:0] i_req_dst = '0;
  logic       o_req_ready;
  logic [4:0] o_8bit_assert_word;
  logic [4:0] o_8bit_load_word;
  logic [3:0] o_16bit_assert_word;
  logic [3:0] o_16bit_load_word;
  logic       o_busy;
  logic       o_err;
  logic [7:0] o_xfer_count;

  always #5 clk = ~clk;

  bus_transfer_sequencer #(.MAX_ID_8(15), .MAX_ID_16(7), .FIFO_DEPTH(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_wide         (i_req_wide),
    .i_req_src          (i_req_src),
    .i_req_dst          (i_req_dst),
    .o_8bit_assert_word (o_8bit_assert_word),
    .o_8bit_load_word   (o_8bit_load_word),
    .o_16bit_assert_word(o_16bit_assert_word),
    .o_16bit_load_word  (o_16bit_load_word),
    .o_busy             (o_busy),
    .o_err              (o_err),
    .o_xfer_count       (o_xfer_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];
  int err_seen;
  int act_cycles;
  int exp_cnt;
  int exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Transfer observed whenever a load word is non-zero, paired with the source asserted alongside it.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_err) err_seen++;
      if (o_8bit_assert_word != 0 || o_8bit_load_word != 0 ||
          o_16bit_assert_word != 0 || o_16bit_load_word != 0) act_cycles++;
      if (o_8bit_load_word != 0)
        obs_q.push_back({1'b0, o_8bit_assert_word, o_8bit_load_word});
      if (o_16bit_load_word != 0)
        obs_q.push_back({1'b1, 1'b0, o_16bit_assert_word, 1'b0, o_16bit_load_word});
    end
  end

  function automatic bit legal(input bit wide, input int src, input int dst);
    int lim;
    lim = wide ? 7 : 15;
    return src >= 1 && dst >= 1 && src <= lim && dst <= lim && src != dst;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit wide, input int src, input int dst);
    int k;
    k = 0;
    i_req_valid = 1'b1;
    i_req_wide  = wide;
    i_req_src   = src[4:0];
    i_req_dst   = dst[4:0];
    while (!o_req_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) check("ready_timeout", 0, 1);
    step();
    i_req_valid = 1'b0;
    if (legal(wide, src, dst)) begin
      exp_q.push_back({wide, src[4:0], dst[4:0]});
      exp_cnt++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic clear_model();
    obs_q.delete();
    exp_q.delete();
    exp_cnt    = 0;
    exp_err    = 0;
    err_seen   = 0;
    act_cycles = 0;
  endtask

  task automatic do_reset();
    i_req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (o_busy && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) check("idle_timeout", 0, 1);
    step();
    step();
  endtask

  task automatic score(input string tag);
    int n;
    check({tag, "_n_xfers"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_xfer%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, "_count"}, o_xfer_count, exp_cnt % 256);
    check({tag, "_errs"}, err_seen, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seq_a [4];
    logic [4:0] seq_l [4];
    logic [7:0] seq_c [4];
    bit w;
    int lim, s, d;

    clear_model();
    step();
    do_reset();

    // Reset state
    check("rst_a8", o_8bit_assert_word, 0);
    check("rst_l8", o_8bit_load_word, 0);
    check("rst_a16", o_16bit_assert_word, 0);
    check("rst_l16", o_16bit_load_word, 0);
    check("rst_ready", o_req_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_count", o_xfer_count, 0);

    // Single 8-bit transfer 1 -> 2: exact phase timing
    push(1'b0, 1, 2);
    check("t1_a8_idle", o_8bit_assert_word, 0);
    check("t1_busy", o_busy, 1);
    seq_a = '{5'd1, 5'd1, 5'd1, 5'd0};
    seq_l = '{5'd0, 5'd2, 5'd0, 5'd0};
    seq_c = '{8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t1_a8_c%0d", i), o_8bit_assert_word, seq_a[i]);
      check($sformatf("t1_l8_c%0d", i), o_8bit_load_word, seq_l[i]);
      check($sformatf("t1_cnt_c%0d", i), o_xfer_count, seq_c[i]);
      check($sformatf("t1_a16_c%0d", i), o_16bit_assert_word, 0);
      check($sformatf("t1_l16_c%0d", i), o_16bit_load_word, 0);
    end
    wait_idle();
    score("t1");

    // 16-bit 3 -> 5 then 8-bit 4 -> 1 back-to-back
    do_reset();
    push(1'b1, 3, 5);
    push(1'b0, 4, 1);
    step();
    check("t2_l16_load", o_16bit_load_word, 5);
    check("t2_a8_quiet", o_8bit_assert_word, 0);
    step();
    check("t2_a16_hold", o_16bit_assert_word, 3);
    step();
    check("t2_a8_setup2", o_8bit_assert_word, 4);
    check("t2_a16_off", o_16bit_assert_word, 0);
    check("t2_cnt_mid", o_xfer_count, 1);
    step();
    check("t2_l8_load2", o_8bit_load_word, 1);
    wait_idle();
    score("t2");

    // Illegal requests: no bus activity, one o_err pulse each
    do_reset();
    push(1'b0, 2, 2);
    push(1'b0, 0, 3);
    push(1'b1, 1, 9);
    wait_idle();
    check("t3_err_pulses", err_seen, 3);
    check("t3_activity", act_cycles, 0);
    score("t3");

    // Queue fills while the first transfer runs; fourth request waits for a pop
    do_reset();
    push(1'b0, 1, 2);
    push(1'b0, 3, 4);
    push(1'b0, 5, 6);
    check("t4_ready_full", o_req_ready, 0);
    push(1'b0, 7, 8);
    wait_idle();
    score("t4");

    // Reset during LOAD with a request still queued
    do_reset();
    push(1'b0, 1, 2);
    push(1'b0, 3, 4);
    step();
    check("t5_in_load", o_8bit_load_word, 2);
    rst = 1'b1;
    step();
    check("t5_a8", o_8bit_assert_word, 0);
    check("t5_l8", o_8bit_load_word, 0);
    check("t5_busy", o_busy, 0);
    check("t5_ready", o_req_ready, 1);
    check("t5_count", o_xfer_count, 0);
    rst = 1'b0;
    clear_model();
    repeat (4) step();
    check("t5_busy_after", o_busy, 0);
    check("t5_activity_after", act_cycles, 0);

    // Randomized mix of legal and illegal requests
    do_reset();
    for (int i = 0; i < 80; i++) begin
      w = $urandom_range(0, 1);
      push(w, $urandom_range(0, 16), $urandom_range(0, 16));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    score("rand");

    // 256 legal transfers wrap the counter to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      w   = $urandom_range(0, 1);
      lim = w ? 7 : 15;
      s   = $urandom_range(1, lim);
      d   = (s % lim) + 1;
      push(w, s, d);
    end
    wait_idle();
    score("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
